// File: rtl/shadow_dump_collector_if.sv
// rtl/shadow_dump_collector_if.sv - chain dump bus and output word stream
interface shadow_dump_collector_if #(
  parameter int CHAINS = 64,
  parameter int WORD_W = 32,
  parameter int CID_W  = $clog2(CHAINS)
);
  logic [CHAINS-1:0] dump_en;
  logic [CHAINS-1:0] ch_out;
  logic [CHAINS-1:0] ch_out_vld;
  logic [CHAINS-1:0] ch_out_done;
  logic [WORD_W-1:0] out_data;
  logic [CID_W-1:0]  out_chain;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output dump_en,
    input  ch_out, ch_out_vld, ch_out_done,
    output out_data, out_chain, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  dump_en,
    output ch_out, ch_out_vld, ch_out_done,
    input  out_data, out_chain, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/shadow_dump_collector.sv
// rtl/shadow_dump_collector.sv - shadow chain dump receiver and word packer
module shadow_dump_collector #(
  parameter int CHAINS  = 64,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CID_W   = $clog2(CHAINS)
) (
  input  logic                    sh_clk,
  input  logic                    sh_rst_l,
  input  logic                    start,
  input  logic [CHAINS-1:0]       chain_mask,
  output logic                    busy,
  output logic                    dump_done,
  output logic                    timeout_err,
  shadow_dump_collector_if.master bus
);
  localparam int WC_W = $clog2(WORD_W);
  localparam int IC_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEEK    = 3'd1;
  localparam logic [2:0] SHIFT   = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] TRAILER = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CHAINS-1:0] mask_q, mask_d;
  logic [CID_W-1:0]  sel_q, sel_d;
  logic [15:0]       bcnt_q, bcnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [IC_W-1:0]   idle_q, idle_d;
  logic              tflag_q, tflag_d;
  logic              terr_q, terr_d;
  logic              done_q, done_d;
  logic [CHAINS-1:0] en_q, en_d;

  // Two-entry output FIFO; head entry drives the stream directly from flops.
  logic [WORD_W-1:0] fd_q [2];
  logic [CID_W-1:0]  fc_q [2];
  logic [1:0]        fl_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fcnt_q;

  logic              push, push_last, wr, pop, fifo_full;
  logic [WORD_W-1:0] push_data;
  logic              vld_take, done_in, bit_in, en_ok;
  logic [WORD_W-1:0] word_w;
  logic [31:0]       trailer;

  assign fifo_full = (fcnt_q == 2'd2);
  assign vld_take  = (state_q == SHIFT) && bus.ch_out_vld[sel_q];
  assign done_in   = (state_q == SHIFT) && bus.ch_out_done[sel_q];
  assign bit_in    = bus.ch_out[sel_q];
  assign trailer   = {15'd0, tflag_q, bcnt_q};
  assign wr        = push && !fifo_full;
  assign pop       = bus.out_valid && bus.out_ready;

  // Dump sequencer: chain walk, bit packing, flush/trailer emission, timeout.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = wcnt_q;
    sreg_d    = sreg_q;
    idle_d    = idle_q;
    tflag_d   = tflag_q;
    terr_d    = terr_q;
    done_d    = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    word_w    = sreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = chain_mask;
          sel_d   = '0;
          terr_d  = 1'b0;
          state_d = SEEK;
        end
      end
      SEEK: begin
        if (mask_q[sel_q]) begin
          bcnt_d  = '0;
          wcnt_d  = '0;
          sreg_d  = '0;
          idle_d  = '0;
          tflag_d = 1'b0;
          state_d = SHIFT;
        end else if (sel_q == CID_W'(CHAINS - 1)) begin
          state_d = DRAIN;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      SHIFT: begin
        if (vld_take) begin
          word_w[wcnt_q] = bit_in;
          idle_d = '0;
          if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
          if (wcnt_q == WC_W'(WORD_W - 1)) begin
            push      = 1'b1;
            push_data = word_w;
            wcnt_d    = '0;
            sreg_d    = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
            sreg_d = word_w;
          end
        end
        // A bit arriving together with done has already been taken above.
        if (done_in) begin
          state_d = FLUSH;
        end else if (!vld_take) begin
          if (idle_q == IC_W'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            tflag_d = 1'b1;
            state_d = FLUSH;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (wcnt_q == '0) begin
          state_d = TRAILER;
        end else if (!fifo_full) begin
          push      = 1'b1;
          push_data = sreg_q;
          wcnt_d    = '0;
          sreg_d    = '0;
          state_d   = TRAILER;
        end
      end
      TRAILER: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_last = 1'b1;
          push_data = WORD_W'(trailer);
          if (sel_q == CID_W'(CHAINS - 1)) begin
            state_d = DRAIN;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = SEEK;
          end
        end
      end
      DRAIN: begin
        if (fcnt_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift enable: at most one bit in flight beyond what the FIFO can absorb.
  always_comb begin
    en_ok = (state_d == SHIFT) && !fifo_full &&
            !((fcnt_q != 2'd0) && (int'(wcnt_q) + int'(vld_take) >= WORD_W - 1));
    en_d  = '0;
    if (en_ok) en_d[sel_d] = 1'b1;
  end

  // Sequencer state registers.
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      state_q <= IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      sreg_q  <= '0;
      idle_q  <= '0;
      tflag_q <= 1'b0;
      terr_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      sreg_q  <= sreg_d;
      idle_q  <= idle_d;
      tflag_q <= tflag_d;
      terr_q  <= terr_d;
      done_q  <= done_d;
      en_q    <= en_d;
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      for (int i = 0; i < 2; i++) begin
        fd_q[i] <= '0;
        fc_q[i] <= '0;
      end
      fl_q     <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fcnt_q   <= 2'd0;
    end else begin
      if (wr) begin
        fd_q[wr_ptr_q] <= push_data;
        fc_q[wr_ptr_q] <= sel_q;
        fl_q[wr_ptr_q] <= push_last;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({wr, pop})
        2'b10:   fcnt_q <= fcnt_q + 2'd1;
        2'b01:   fcnt_q <= fcnt_q - 2'd1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  assign bus.dump_en   = en_q;
  assign bus.out_valid = (fcnt_q != 2'd0);
  assign bus.out_data  = fd_q[rd_ptr_q];
  assign bus.out_chain = fc_q[rd_ptr_q];
  assign bus.out_last  = fl_q[rd_ptr_q];
  assign busy          = (state_q != IDLE) || done_q;
  assign dump_done     = done_q;
  assign timeout_err   = terr_q;
endmodule
